// File: rtl/fp_add_pkg.sv
// Shared binary32 definitions for the fp_add_test adder pipeline.
// Holds field widths, special constants and the unpacked-operand view.
package fp_add_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int LATENCY = 4;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   mant;
    logic              is_zero;
    logic              is_fin;
    logic              is_inf;
    logic              is_nan;
  } fp_op_t;

  // Subnormals fold into zero here, so downstream only sees normal significands.
  function automatic fp_op_t fp_unpack(input logic [31:0] v);
    fp_op_t o;
    o.sign    = v[31];
    o.exp     = v[30:23];
    o.is_zero = (v[30:23] == '0);
    o.is_inf  = (&v[30:23]) & (v[22:0] == '0);
    o.is_nan  = (&v[30:23]) & (|v[22:0]);
    o.is_fin  = ~o.is_zero & ~(&v[30:23]);
    o.mant    = o.is_zero ? '0 : {1'b1, v[22:0]};
    return o;
  endfunction

endpackage

// File: rtl/fp_lzc25.sv
// Leading-zero counter for the 25-bit adder sum; an all-zero input reports 25.
// Latency: combinational. Backpressure: none.
module fp_lzc25 (
  input  logic [24:0] d,
  output logic [4:0]  cnt
);

  always_comb begin
    cnt = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (d[i]) cnt = 5'(24 - i);
    end
  end

endmodule

// File: rtl/fp_add_test.sv
// Pipelined binary32 adder, round-to-nearest-even, flush-to-zero.
// Latency: 4 edges from the sampling edge. Backpressure: none, one op per cycle.
module fp_add_test
  import fp_add_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] A1,
  input  logic [31:0] B1,
  output logic [31:0] Result
);

  // Assert asynchronously, release on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [31:0] a_q, b_q;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= A1;
      b_q <= B1;
    end
  end

  // ---------------- stage 1: unpack, classify, swap ----------------
  fp_op_t ua, ub;
  assign ua = fp_unpack(a_q);
  assign ub = fp_unpack(b_q);

  logic        swap;
  logic        x_sign, y_sign;
  logic [7:0]  x_exp, y_exp, diff_raw, diff_sat;
  logic [23:0] x_mant, y_mant;
  logic        spec;
  logic [31:0] spec_val;

  always_comb begin
    swap     = {ub.exp, ub.mant} > {ua.exp, ua.mant};
    x_sign   = swap ? ub.sign : ua.sign;
    y_sign   = swap ? ua.sign : ub.sign;
    x_exp    = swap ? ub.exp  : ua.exp;
    y_exp    = swap ? ua.exp  : ub.exp;
    x_mant   = swap ? ub.mant : ua.mant;
    y_mant   = swap ? ua.mant : ub.mant;
    diff_raw = x_exp - y_exp;
    diff_sat = (diff_raw > 8'd26) ? 8'd26 : diff_raw;
  end

  // Anything other than two nonzero finite operands resolves here.
  always_comb begin
    spec     = ~(ua.is_fin & ub.is_fin);
    spec_val = 32'h0;
    if (ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_inf & (ua.sign ^ ub.sign)))
      spec_val = QNAN;
    else if (ua.is_inf)
      spec_val = {ua.sign, 8'hFF, 23'h0};
    else if (ub.is_inf)
      spec_val = {ub.sign, 8'hFF, 23'h0};
    else if (ua.is_zero & ub.is_zero)
      spec_val = {ua.sign & ub.sign, 31'h0};
    else if (ua.is_zero)
      spec_val = b_q;
    else if (ub.is_zero)
      spec_val = a_q;
  end

  logic        s1_spec, s1_sign, s1_sub;
  logic [31:0] s1_spec_val;
  logic [7:0]  s1_exp, s1_diff;
  logic [23:0] s1_xm, s1_ym;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_spec     <= 1'b0;
      s1_spec_val <= '0;
      s1_sign     <= 1'b0;
      s1_sub      <= 1'b0;
      s1_exp      <= '0;
      s1_diff     <= '0;
      s1_xm       <= '0;
      s1_ym       <= '0;
    end else begin
      s1_spec     <= spec;
      s1_spec_val <= spec_val;
      s1_sign     <= x_sign;
      s1_sub      <= x_sign ^ y_sign;
      s1_exp      <= x_exp;
      s1_diff     <= diff_sat;
      s1_xm       <= x_mant;
      s1_ym       <= y_mant;
    end
  end

  // ---------------- stage 2: align smaller significand ----------------
  // Upper 26 bits are significand+G+R; everything shifted below them is sticky.
  logic [51:0] wide;
  assign wide = {s1_ym, 28'd0} >> s1_diff;

  logic        s2_spec, s2_sign, s2_sub, s2_sticky;
  logic [31:0] s2_spec_val;
  logic [7:0]  s2_exp;
  logic [23:0] s2_xm;
  logic [25:0] s2_ym;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      s2_spec     <= 1'b0;
      s2_spec_val <= '0;
      s2_sign     <= 1'b0;
      s2_sub      <= 1'b0;
      s2_sticky   <= 1'b0;
      s2_exp      <= '0;
      s2_xm       <= '0;
      s2_ym       <= '0;
    end else begin
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
      s2_sign     <= s1_sign;
      s2_sub      <= s1_sub;
      s2_sticky   <= |wide[25:0];
      s2_exp      <= s1_exp;
      s2_xm       <= s1_xm;
      s2_ym       <= wide[51:26];
    end
  end

  // ---------------- stage 3: add / subtract ----------------
  logic [27:0] op_x, op_y, sum;

  always_comb begin
    op_x = {1'b0, s2_xm, 3'b000};
    op_y = {1'b0, s2_ym, s2_sticky};
    sum  = s2_sub ? (op_x - op_y) : (op_x + op_y);
  end

  logic        s3_spec, s3_sign;
  logic [31:0] s3_spec_val;
  logic [7:0]  s3_exp;
  logic [27:0] s3_sum;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      s3_spec     <= 1'b0;
      s3_spec_val <= '0;
      s3_sign     <= 1'b0;
      s3_exp      <= '0;
      s3_sum      <= '0;
    end else begin
      s3_spec     <= s2_spec;
      s3_spec_val <= s2_spec_val;
      s3_sign     <= s2_sign;
      s3_exp      <= s2_exp;
      s3_sum      <= sum;
    end
  end

  // ---------------- stage 4: normalise, round, pack ----------------
  logic [4:0] lz;

  fp_lzc25 u_lzc (
    .d   (s3_sum[27:3]),
    .cnt (lz)
  );

  logic [4:0]  lsh;
  logic [26:0] norm;
  logic [9:0]  exp_n, exp_f;
  logic        rnd;
  logic [24:0] mant_r;
  logic [22:0] frac_f;
  logic        under, over;
  logic [31:0] res_d;

  always_comb begin
    lsh = lz - 5'd1;
    if (lz == 5'd0) begin
      norm  = {s3_sum[27:2], s3_sum[1] | s3_sum[0]};
      exp_n = {2'b00, s3_exp} + 10'd1;
    end else begin
      norm  = s3_sum[26:0] << lsh;
      exp_n = {2'b00, s3_exp} - {5'b00000, lsh};
    end
    // norm[26:3] significand, [2] guard, [1] round, [0] sticky
    rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[26:3]} + {24'd0, rnd};
    frac_f = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    exp_f  = mant_r[24] ? (exp_n + 10'd1) : exp_n;
    under  = exp_f[9] | (exp_f == 10'd0);
    over   = ~exp_f[9] & (exp_f >= 10'd255);

    if (s3_spec)             res_d = s3_spec_val;
    else if (s3_sum == '0)   res_d = 32'h0;
    else if (under)          res_d = {s3_sign, 31'h0};
    else if (over)           res_d = {s3_sign, 8'hFF, 23'h0};
    else                     res_d = {s3_sign, exp_f[7:0], frac_f};
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) Result <= '0;
    else        Result <= res_d;
  end

endmodule

// File: tb/tb_fp_add_test.sv
// Directed scoreboard bench for fp_add_test: every cycle's expected Result is
// queued when its inputs are driven and compared when it reaches the output.
module tb_fp_add_test;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] A1 = '0;
  logic [31:0] B1 = '0;
  logic [31:0] Result;

  int errors = 0;
  int checks = 0;

  logic [31:0] qexp[$];
  string       qtag[$];

  fp_add_test dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .A1      (A1),
    .B1      (B1),
    .Result  (Result)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: Result=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // Inputs driven at negedge k are sampled at the next posedge and come out
  // four posedges after that, i.e. they are seen at negedge k+5.
  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input string tag);
    string       t;
    logic [31:0] x;
    @(negedge aclk);
    if (qexp.size() == 5) begin
      t = qtag.pop_front();
      x = qexp.pop_front();
      check(t, Result, x);
    end
    A1 = a;
    B1 = b;
    qexp.push_back(e);
    qtag.push_back(tag);
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    check("reset_hold", Result, 32'h0);
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) step(32'h0, 32'h0, 32'h0, "idle_after_reset");

    step(32'h3FC00000, 32'h40200000, 32'h40800000, "add_1p5_2p5");
    step(32'h0, 32'h0, 32'h0, "gap0");
    step(32'h0, 32'h0, 32'h0, "gap1");
    step(32'h0, 32'h0, 32'h0, "gap2");
    step(32'h0, 32'h0, 32'h0, "gap3");
    step(32'h0, 32'h0, 32'h0, "gap4");

    // back-to-back stream
    step(32'hBFC00000, 32'h3FC00000, 32'h00000000, "cancel");
    step(32'h3FC00000, 32'h3FC00000, 32'h40400000, "add_1p5_1p5");
    step(32'h3F800000, 32'h33800000, 32'h3F800000, "tie_even");
    step(32'h3F800001, 32'h33800000, 32'h3F800002, "tie_odd");
    step(32'h3F800000, 32'h33C00000, 32'h3F800001, "above_half");
    step(32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf");
    step(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow");
    step(32'h7F7FFFFF, 32'h73000000, 32'h7F800000, "round_overflow");
    step(32'h00000001, 32'h00000000, 32'h00000000, "ftz_input");
    step(32'h80000000, 32'h80000000, 32'h80000000, "negz_negz");
    step(32'h80000000, 32'h00000000, 32'h00000000, "negz_posz");
    step(32'h00000000, 32'h3F800000, 32'h3F800000, "zero_plus_x");
    step(32'hC0490FDB, 32'h80000000, 32'hC0490FDB, "x_plus_negz");
    step(32'h7F800001, 32'h3F800000, 32'h7FC00000, "nan_in");
    step(32'hFF800000, 32'h3F800000, 32'hFF800000, "neginf_plus_x");
    step(32'h7F800000, 32'h7F800000, 32'h7F800000, "inf_plus_inf");
    step(32'h40000000, 32'hBF800000, 32'h3F800000, "two_minus_one");
    step(32'h00800001, 32'h80800000, 32'h00000000, "underflow_pos");
    step(32'h80800001, 32'h00800000, 32'h80000000, "underflow_neg");
    step(32'h3F800001, 32'h4C800000, 32'h4C800000, "shift_sat");
    step(32'h40400000, 32'h40400000, 32'h40C00000, "inflight0");
    step(32'h40000000, 32'h40000000, 32'h40800000, "inflight1");
    step(32'h3F800000, 32'h3F800000, 32'h40000000, "inflight2");
    step(32'h40800000, 32'h40800000, 32'h41000000, "inflight3");
    step(32'h41000000, 32'h41000000, 32'h41800000, "inflight4");

    // mid-stream reset: everything in flight is discarded
    @(negedge aclk);
    aresetn = 1'b0;
    A1 = 32'h0;
    B1 = 32'h0;
    #1;
    check("reset_async", Result, 32'h0);
    qexp.delete();
    qtag.delete();
    @(negedge aclk);
    check("reset_held", Result, 32'h0);
    aresetn = 1'b1;
    for (int i = 0; i < 8; i++) step(32'h0, 32'h0, 32'h0, "no_stale");

    step(32'hC0000000, 32'h3F800000, 32'hBF800000, "post_reset_op");
    for (int i = 0; i < 5; i++) step(32'h0, 32'h0, 32'h0, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_add_test.md
FP_ADD_TEST -- requirements
Module: fp_add_test

Interface
REQ-001 The block SHALL have no parameters; format is IEEE-754 binary32 and latency is fixed.
REQ-002 aclk  input  1  single clock; all state updates on its rising edge.
REQ-003 aresetn  input  1  reset, asynchronous and active-low.
REQ-004 A1  input  32  addend A, binary32 (sign[31], exponent[30:23], fraction[22:0]).
REQ-005 B1  input  32  addend B, binary32.
REQ-006 Result  output  32  registered binary32 value of A1+B1.

Function
REQ-007 The block SHALL sample A1/B1 on every rising aclk edge, with no handshake or valid signal.
REQ-008 The block SHALL be fully pipelined: one new operation per cycle; Result for inputs sampled at edge N appears after edge N+4 (latency 4).
REQ-009 Stage 1 SHALL unpack, classify (zero, finite, inf, NaN), and swap so the larger magnitude is operand X.
REQ-010 Stage 2 SHALL right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits; a shift of 26 or more leaves only sticky.
REQ-011 Stage 3 SHALL add the significands (same signs) or subtract them (different signs), giving a 25-bit sum plus G/R/S.
REQ-012 Stage 4 SHALL normalise (1-bit right shift on carry; left shift by leading-zero count otherwise), round to nearest ties-to-even, renormalise on rounding carry, and register Result.
REQ-013 Subnormal inputs SHALL be treated as zero of the same sign (flush-to-zero).
REQ-014 Results whose exponent falls below 1 SHALL flush to signed zero with the computed sign.
REQ-015 Results whose exponent reaches 255 after rounding SHALL be infinity with the computed sign.
REQ-016 Exact cancellation of finite operands (x + -x) SHALL give +0 (0x00000000).
REQ-017 Sum of two zeros SHALL be -0 only when both are -0; otherwise +0.
REQ-018 A zero plus a nonzero finite operand SHALL return the nonzero operand unchanged.
REQ-019 Any NaN input, or +inf plus -inf, SHALL give canonical quiet NaN 0x7FC00000.
REQ-020 Infinity plus finite, or infinity plus the same-signed infinity, SHALL give that infinity.
REQ-021 Arithmetic widths: 24-bit significand with hidden bit, 8-bit exponent difference saturated at 26, 5-bit leading-zero count.

Reset
REQ-022 While aresetn is low, all pipeline registers and Result SHALL clear to 0 asynchronously.
REQ-023 After reset, Result SHALL stay 0x00000000 until the first operation sampled after reset deassertion completes 4 edges later.
REQ-024 Reset deassertion SHALL be used synchronised to aclk.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight operations.

Structure
REQ-026 Package fp_add_pkg SHALL hold: binary32 field widths, bias 127, QNAN constant 0x7FC00000, an unpacked-operand struct (sign, exp, mant, class flags), and the LATENCY=4 constant.
REQ-027 Leading-zero counting SHALL be a single sub-module, fp_lzc25 (25-bit input, 5-bit count output).
REQ-028 Stage logic SHALL remain inline in fp_add_test.

Verification
REQ-029 0x3FC00000 + 0x40200000 (1.5+2.5) -> Result 0x40800000 (4.0) exactly 4 edges later.
REQ-030 0xBFC00000 + 0x3FC00000 (-1.5+1.5) -> 0x00000000; 0x3FC00000 + 0x3FC00000 -> 0x40400000 (3.0).
REQ-031 Back-to-back inputs, a new pair each cycle -> results in order, one per cycle, each 4 edges after its inputs.
REQ-032 Rounding: 0x3F800000 + 0x33800000 (1.0 + 2^-24, tie) -> 0x3F800000; 0x3F800001 + 0x33800000 -> 0x3F800002.
REQ-033 Specials: 0x7F800000 + 0xFF800000 -> 0x7FC00000; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000; 0x00000001 + 0x00000000 -> 0x00000000 (FTZ).
REQ-034 aresetn pulsed low mid-stream -> Result immediately 0x00000000 and no stale result appears afterwards.
